// File: rtl/boot_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : boot_vga_timing
// Purpose  : 640x480@60 VGA raster timing generator plus the boot-screen
//            loading-animation offset counter. The animation offset only
//            moves on the frame-wrap edge, so the logo never tears mid-frame.
// Ports    : clk            - system clock
//            reset_n        - asynchronous active-low reset
//            pixel_ce       - pixel clock enable; all state advances only when 1
//            anim_en        - enables loading-animation stepping
//            hpos / vpos    - registered raster counters
//            hsync / vsync  - active-low syncs (decoded from hpos/vpos)
//            display_on     - high inside the visible area
//            frame_tick     - one-clock pulse coincident with hpos=vpos=0
//            loading_offset - animation offset for the logo generator
// Revision : 1.0 - initial release
// ============================================================================
module boot_vga_timing #(
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33,
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned OFFSET_MAX      = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pixel_ce,
    input  logic       anim_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_tick,
    output logic [9:0] loading_offset
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Prescaler needs at least one bit even when it only ever holds 0.
    localparam int unsigned PRE_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [9:0]       c_h_last   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       c_v_last   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       c_h_vis    = 10'(H_VISIBLE);
    localparam logic [9:0]       c_v_vis    = 10'(V_VISIBLE);
    localparam logic [9:0]       c_hs_start = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]       c_hs_end   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]       c_vs_start = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]       c_vs_end   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]       c_off_last = 10'(OFFSET_MAX - 1);
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(FRAMES_PER_STEP - 1);

    logic [9:0]       hpos_q, hpos_d;
    logic [9:0]       vpos_q, vpos_d;
    logic [9:0]       off_q, off_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q;

    logic             w_h_last;
    logic             w_v_last;
    logic             w_frame_wrap;

    always_comb begin
        w_h_last     = (hpos_q == c_h_last);
        w_v_last     = (vpos_q == c_v_last);
        // Single enable for everything that happens at the end of a frame.
        w_frame_wrap = pixel_ce && w_h_last && w_v_last;

        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (pixel_ce) begin
            if (w_h_last) begin
                hpos_d = 10'd0;
                vpos_d = w_v_last ? 10'd0 : (vpos_q + 10'd1);
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end

        pre_d = pre_q;
        off_d = off_q;
        if (w_frame_wrap && anim_en) begin
            if (pre_q == c_pre_last) begin
                pre_d = '0;
                off_d = (off_q == c_off_last) ? 10'd0 : (off_q + 10'd1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hpos_q <= 10'd0;
            vpos_q <= 10'd0;
            off_q  <= 10'd0;
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            off_q  <= off_d;
            pre_q  <= pre_d;
            // Registered copy of the wrap, so it lines up with hpos=vpos=0.
            tick_q <= w_frame_wrap;
        end
    end

    assign hpos           = hpos_q;
    assign vpos           = vpos_q;
    assign loading_offset = off_q;
    assign frame_tick     = tick_q;
    assign hsync          = !((hpos_q >= c_hs_start) && (hpos_q < c_hs_end));
    assign vsync          = !((vpos_q >= c_vs_start) && (vpos_q < c_vs_end));
    assign display_on     = (hpos_q < c_h_vis) && (vpos_q < c_v_vis);

endmodule
`default_nettype wire

// File: tb/tb_boot_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_vga_timing
// Purpose  : Directed bench. DUT A uses the default 640x480 timing and is
//            checked over single lines; DUT B uses a miniature raster
//            (23 x 10, frame = 230 enables, FRAMES_PER_STEP=2, OFFSET_MAX=3)
//            so whole frames and the animation stepping fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_vga_timing;

    logic clk      = 1'b0;
    logic reset_n  = 1'b1;
    logic pixel_ce = 1'b0;
    logic anim_en  = 1'b1;

    logic [9:0] a_hpos, a_vpos, a_off;
    logic       a_hsync, a_vsync, a_disp, a_tick;
    logic [9:0] b_hpos, b_vpos, b_off;
    logic       b_hsync, b_vsync, b_disp, b_tick;

    always #5 clk = ~clk;

    boot_vga_timing u_dut_a (
        .clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .anim_en(anim_en),
        .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hsync), .vsync(a_vsync),
        .display_on(a_disp), .frame_tick(a_tick), .loading_offset(a_off)
    );

    boot_vga_timing #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .FRAMES_PER_STEP(2), .OFFSET_MAX(3)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .anim_en(anim_en),
        .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
        .display_on(b_disp), .frame_tick(b_tick), .loading_offset(b_off)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc, last_tick, vs_low, hs_low;
    logic [9:0] prev_off;
    bit         off_glitch;

    localparam logic [63:0] RESET_VEC = {30'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the edge, with running monitors on DUT B.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!b_vsync) vs_low++;
        if (!b_hsync) hs_low++;
        if (b_off !== prev_off && !b_tick) off_glitch = 1'b1;
        prev_off = b_off;
    endtask

    // Asynchronous reset pulse; outputs are checked before any clock edge occurs.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check({tag, " A reset"}, {30'd0, a_hpos, a_vpos, a_hsync, a_vsync, a_disp, a_tick, a_off}, RESET_VEC);
        check({tag, " B reset"}, {30'd0, b_hpos, b_vpos, b_hsync, b_vsync, b_disp, b_tick, b_off}, RESET_VEC);
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        cyc        = 0;
        last_tick  = 0;
        vs_low     = 0;
        hs_low     = 0;
        prev_off   = 10'd0;
        off_glitch = 1'b0;
    endtask

    // Run DUT B (pixel_ce held at 1) to its next frame_tick and check it.
    task automatic wait_wrap(input string tag, input logic [9:0] exp_off);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!b_tick && n < 400);
        check({tag, " tick"}, 64'(b_tick), 64'd1);
        check({tag, " period"}, 64'(cyc - last_tick), 64'd230);
        check({tag, " pos"}, {44'd0, b_hpos, b_vpos}, 64'd0);
        check({tag, " offset"}, 64'(b_off), 64'(exp_off));
        check({tag, " glitch"}, 64'(off_glitch), 64'd0);
        last_tick = cyc;
    endtask

    initial begin
        int a_low, first_lo, last_lo;

        // ---- Reset and basic horizontal counting (default timing) ----
        do_reset("init");
        pixel_ce = 1'b1;
        step();
        check("A hpos first", 64'(a_hpos), 64'd1);
        check("B hpos first", 64'(b_hpos), 64'd1);
        step();
        check("A hpos second", 64'(a_hpos), 64'd2);
        repeat (637) step();
        check("A disp at 639", {53'd0, a_hpos, a_disp}, {53'd0, 10'd639, 1'b1});
        step();
        check("A disp at 640", {53'd0, a_hpos, a_disp}, {53'd0, 10'd640, 1'b0});

        a_low    = 0;
        first_lo = -1;
        last_lo  = -1;
        for (int i = 641; i <= 800; i++) begin
            step();
            if (!a_hsync) begin
                if (first_lo < 0) first_lo = int'(a_hpos);
                last_lo = int'(a_hpos);
                a_low++;
            end
        end
        check("A hsync width", 64'(a_low), 64'd96);
        check("A hsync first", 64'(first_lo), 64'd656);
        check("A hsync last", 64'(last_lo), 64'd751);
        check("A line wrap", {44'd0, a_hpos, a_vpos}, {44'd0, 10'd0, 10'd1});
        // 800 enables on the mini raster: 3 frames + 110 -> line 4, pixel 18.
        check("B pos at 800", {43'd0, b_hpos, b_vpos, b_hsync}, {43'd0, 10'd18, 10'd4, 1'b0});
        check("B offset at 800", 64'(b_off), 64'd1);

        // ---- Frames and animation stepping on DUT B ----
        do_reset("anim");
        wait_wrap("w1", 10'd0);
        check("B vsync low f1", 64'(vs_low), 64'd46);
        check("B hsync low f1", 64'(hs_low), 64'd30);
        wait_wrap("w2", 10'd1);
        check("B vsync low f2", 64'(vs_low), 64'd92);
        wait_wrap("w3", 10'd1);
        wait_wrap("w4", 10'd2);
        wait_wrap("w5", 10'd2);
        wait_wrap("w6", 10'd0);
        wait_wrap("w7", 10'd0);
        wait_wrap("w8", 10'd1);
        wait_wrap("w9", 10'd1);
        // Prescaler is now 1; freeze it mid-frame for two wraps.
        repeat (115) step();
        anim_en = 1'b0;
        wait_wrap("w10 hold", 10'd1);
        wait_wrap("w11 hold", 10'd1);
        repeat (115) step();
        anim_en = 1'b1;
        wait_wrap("w12 resume", 10'd2);
        wait_wrap("w13", 10'd2);

        // ---- pixel_ce at half rate ----
        do_reset("ce");
        for (int c = 1; c <= 800; c++) begin
            pixel_ce = 1'b1;
            step();
            if (c == 1) check("A half-rate ce1", 64'(a_hpos), 64'd1);
            if (c == 230) check("B tick on wrap", {43'd0, b_tick, b_hpos, b_vpos}, {43'd0, 1'b1, 20'd0});
            pixel_ce = 1'b0;
            step();
            if (c == 1) check("A half-rate ce0", 64'(a_hpos), 64'd1);
            if (c == 230) check("B tick drop ce0", {43'd0, b_tick, b_hpos, b_vpos}, 64'd0);
        end
        check("A 1600 clk line", {44'd0, a_hpos, a_vpos}, {44'd0, 10'd0, 10'd1});

        // ---- Asynchronous reset mid-frame with a partial prescaler count ----
        pixel_ce = 1'b1;
        repeat (80) step();
        check("A pre-reset pos", {44'd0, a_hpos, a_vpos}, {44'd0, 10'd80, 10'd1});
        check("B pre-reset pos", {44'd0, b_hpos, b_vpos}, {44'd0, 10'd6, 10'd8});
        check("B pre-reset off", 64'(b_off), 64'd1);
        do_reset("mid");
        wait_wrap("pr1", 10'd0);
        wait_wrap("pr2", 10'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
